// File: rtl/code_memory_loader.sv
// Boot loader: parses framed byte stream, assembles little-endian words and
// writes them into the code memory while holding the CPU in reset.
module code_memory_loader #(
   parameter int         WORDS     = 20000,
   parameter int         ADDR_W    = 15,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   output logic              cpu_reset_req,
   output logic              busy,
   output logic              load_ok,
   output logic              load_err,
   output logic [1:0]        err_code
);

   typedef enum logic [2:0] {
      IDLE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA, WRITE, CSUM
   } state_t;

   localparam logic [16:0] WORDS17 = 17'(WORDS);

   // Handshake: a byte transfers on a rising clk edge where s_valid & s_ready.
   state_t            state;
   logic [ADDR_W-1:0] start;
   logic [15:0]       cnt;
   logic [15:0]       idx;
   logic [7:0]        sum;
   logic [31:0]       word;
   logic [1:0]        byte_cnt;
   logic              acc;
   logic [16:0]       start17;
   logic [16:0]       cnt17;
   logic              range_err;
   logic [15:0]       idx_next;

   assign mem_clken = 1'b1;
   assign acc       = s_valid & s_ready;
   assign idx_next  = idx + 16'd1;

   // Range check in 17 bits so start + CNT cannot wrap.
   always_comb begin
      start17   = 17'(start);
      cnt17     = {1'b0, s_data, cnt[7:0]};
      range_err = (start17 >= WORDS17) || (cnt17 == 17'd0) ||
                  ((start17 + cnt17) > WORDS17);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         s_ready        <= 1'b0;
         start          <= '0;
         cnt            <= '0;
         idx            <= '0;
         sum            <= '0;
         word           <= '0;
         byte_cnt       <= '0;
         mem_address    <= '0;
         mem_byteenable <= 4'h0;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         cpu_reset_req  <= 1'b0;
         busy           <= 1'b0;
         load_ok        <= 1'b0;
         load_err       <= 1'b0;
         err_code       <= 2'b00;
      end else begin
         mem_write      <= 1'b0;
         mem_chipselect <= 1'b0;
         mem_byteenable <= 4'h0;
         // Drop ready only for the single WRITE cycle that follows byte 3.
         s_ready <= !(state == DATA && acc && byte_cnt == 2'd3);
         case (state)
            IDLE: begin
               if (acc && s_data == SYNC_BYTE) begin
                  state         <= ADDR_LO;
                  load_ok       <= 1'b0;
                  load_err      <= 1'b0;
                  err_code      <= 2'b00;
                  cpu_reset_req <= 1'b1;
                  busy          <= 1'b1;
               end
            end
            ADDR_LO: if (acc) begin
               start[7:0] <= s_data;
               state      <= ADDR_HI;
            end
            ADDR_HI: if (acc) begin
               start[ADDR_W-1:8] <= s_data[ADDR_W-9:0];
               state             <= CNT_LO;
            end
            CNT_LO: if (acc) begin
               cnt[7:0] <= s_data;
               state    <= CNT_HI;
            end
            CNT_HI: if (acc) begin
               cnt[15:8] <= s_data;
               if (range_err) begin
                  state         <= IDLE;
                  load_err      <= 1'b1;
                  err_code      <= 2'b01;
                  cpu_reset_req <= 1'b0;
                  busy          <= 1'b0;
               end else begin
                  state    <= DATA;
                  idx      <= '0;
                  sum      <= '0;
                  byte_cnt <= '0;
               end
            end
            DATA: if (acc) begin
               word     <= {s_data, word[31:8]};
               sum      <= sum + s_data;
               byte_cnt <= byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) begin
                  state          <= WRITE;
                  mem_write      <= 1'b1;
                  mem_chipselect <= 1'b1;
                  mem_byteenable <= 4'hF;
                  mem_address    <= start + idx[ADDR_W-1:0];
                  mem_writedata  <= {s_data, word[31:8]};
               end
            end
            WRITE: begin
               idx   <= idx_next;
               state <= (idx_next == cnt) ? CSUM : DATA;
            end
            CSUM: if (acc) begin
               state         <= IDLE;
               cpu_reset_req <= 1'b0;
               busy          <= 1'b0;
               if (s_data == sum) begin
                  load_ok <= 1'b1;
               end else begin
                  load_err <= 1'b1;
                  err_code <= 2'b10;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_code_memory_loader.sv
// Directed bench for code_memory_loader: expected writes queued by the
// stimulus, popped and compared by a monitor on each mem_write pulse.
module tb_code_memory_loader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [14:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic        cpu_reset_req;
   logic        busy;
   logic        load_ok;
   logic        load_err;
   logic [1:0]  err_code;

   int checks = 0;
   int errors = 0;
   logic [46:0] exp_q[$];
   logic [31:0] wbuf[4];

   code_memory_loader dut (
      .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .mem_address(mem_address),
      .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata),
      .mem_clken(mem_clken), .cpu_reset_req(cpu_reset_req), .busy(busy),
      .load_ok(load_ok), .load_err(load_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse must match the head of the expected queue.
   always @(negedge clk) begin
      if (mem_write) begin
         logic [46:0] e;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data %h, none expected",
                     mem_address, mem_writedata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(mem_address), 32'(e[46:32]));
            check("wr_data", mem_writedata, e[31:0]);
            check("wr_be_cs", {27'd0, mem_chipselect, mem_byteenable}, 32'h1F);
         end
      end
   end

   // Inputs change 1 time unit after a rising edge; returns just after the
   // edge on which the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit done = 0;
      s_data  = b;
      s_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (s_ready) done = 1;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL byte_accept_timeout: byte %h not accepted, need 1", b);
      end
      if (gap > 0) begin
         s_valid = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic send_header(input logic [15:0] start, input logic [15:0] cnt,
                              input int gap);
      send_byte(8'hA5, gap);
      check("busy_after_sync", {30'd0, cpu_reset_req, busy}, 32'h3);
      send_byte(start[7:0], gap);
      send_byte(start[15:8], gap);
      send_byte(cnt[7:0], gap);
      send_byte(cnt[15:8], gap);
   endtask

   task automatic send_body(input int nwords, input logic [7:0] csum,
                            input int gap);
      for (int w = 0; w < nwords; w++)
         for (int k = 0; k < 4; k++) send_byte(wbuf[w][8*k +: 8], gap);
      check("busy_before_csum", {31'd0, cpu_reset_req}, 32'h1);
      send_byte(csum, gap);
   endtask

   task automatic check_status(input string name, input logic ok,
                               input logic err, input logic [1:0] code);
      check(name, {27'd0, cpu_reset_req, load_ok, load_err, err_code},
            {27'd0, 1'b0, ok, err, code});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {s_ready, mem_write, mem_chipselect, mem_byteenable, cpu_reset_req,
             busy, load_ok, load_err, err_code, 16'd0, 3'd0},
            32'd0);
      check("reset_addr_data", {17'd0, mem_address} | mem_writedata, 32'd0);
      check("clken", {31'd0, mem_clken}, 32'h1);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", {31'd0, s_ready}, 32'h1);

      wbuf[0] = 32'h44332211;
      wbuf[1] = 32'h88776655;

      // Basic two-word frame, continuous stream.
      exp_q.push_back({15'd0, 32'h44332211});
      exp_q.push_back({15'd1, 32'h88776655});
      send_header(16'd0, 16'd2, 0);
      send_body(2, 8'h64, 0);
      check_status("frame_ok", 1'b1, 1'b0, 2'b00);

      // Same frame with s_valid toggling.
      exp_q.push_back({15'd0, 32'h44332211});
      exp_q.push_back({15'd1, 32'h88776655});
      send_header(16'd0, 16'd2, 1);
      send_body(2, 8'h64, 1);
      check_status("frame_ok_gappy", 1'b1, 1'b0, 2'b00);

      // Start 19999, CNT 2: range error after CNT_HI.
      send_header(16'h4E1F, 16'd2, 0);
      check_status("range_end", 1'b0, 1'b1, 2'b01);

      // Start 19999, CNT 1: last word of memory.
      wbuf[0] = 32'hDEADBEEF;
      exp_q.push_back({15'd19999, 32'hDEADBEEF});
      send_header(16'h4E1F, 16'd1, 0);
      send_body(1, 8'h38, 0);
      check_status("last_word_ok", 1'b1, 1'b0, 2'b00);

      // Bad checksum: words still written.
      wbuf[0] = 32'h44332211;
      exp_q.push_back({15'd0, 32'h44332211});
      exp_q.push_back({15'd1, 32'h88776655});
      send_header(16'd0, 16'd2, 0);
      send_body(2, 8'h65, 0);
      check_status("csum_err", 1'b0, 1'b1, 2'b10);

      // Junk before a frame, at a non-zero start address.
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h13, 0);
      exp_q.push_back({15'd256, 32'h44332211});
      send_header(16'h0100, 16'd1, 0);
      send_body(1, 8'hAA, 0);
      check_status("junk_then_ok", 1'b1, 1'b0, 2'b00);

      // CNT = 0.
      send_header(16'd5, 16'd0, 0);
      check_status("cnt_zero", 1'b0, 1'b1, 2'b01);

      // Reset after the 2nd data byte of a word.
      send_header(16'd10, 16'd1, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      s_valid = 1'b0;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("midframe_reset",
            {27'd0, s_ready, mem_write, cpu_reset_req, load_ok, load_err},
            32'd0);
      check("midframe_reset_code", {30'd0, err_code}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back({15'd0, 32'h44332211});
      exp_q.push_back({15'd1, 32'h88776655});
      send_header(16'd0, 16'd2, 0);
      send_body(2, 8'h64, 0);
      check_status("after_reset_ok", 1'b1, 1'b0, 2'b00);

      repeat (4) @(posedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, need finish");
      $fatal(1);
   end

endmodule

// File: doc/code_memory_loader.md
# code_memory_loader

Byte-stream boot loader that sits directly upstream of the on-chip code memory (32-bit, 15-bit word address, 20000 words, single port, no wait states). It parses a framed byte stream (from the UART/JTAG bridge), assembles little-endian 32-bit words and writes them into the code memory through its write port. While a frame is in progress it holds the CPU in reset and asserts the memory's reset_req, keeping fetches off the RAM.

## Interface
- WORDS, 20000, code memory depth in words
- ADDR_W, 15, word address width
- SYNC_BYTE, 8'hA5, frame start marker
- clk  in  1  single clock for all logic
- reset_n  in  1  synchronous, active-low reset
- s_data  in  8  incoming byte
- s_valid  in  1  s_data valid
- s_ready  out  1  byte accepted on a clk edge where s_valid & s_ready
- mem_address  out  ADDR_W  word address to code memory
- mem_byteenable  out  4  always 4'hF during writes, 4'h0 otherwise
- mem_chipselect  out  1  write strobe qualifier
- mem_write  out  1  write strobe
- mem_writedata  out  32  assembled word
- mem_clken  out  1  tied 1
- cpu_reset_req  out  1  high while a frame is active; drives CPU reset and memory reset_req
- busy  out  1  equals cpu_reset_req
- load_ok  out  1  last frame completed with good checksum
- load_err  out  1  last frame failed
- err_code  out  2  01 range error, 10 checksum error, 00 none

## Operation
- Frame: SYNC_BYTE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, 4*CNT data bytes (byte 0 = bits 7:0), CSUM.
- CSUM = 8-bit modulo-256 sum of all data bytes only.
- States: IDLE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA, WRITE, CSUM.
- IDLE: s_ready=1; non-sync bytes discarded. Accepting SYNC_BYTE -> ADDR_LO; load_ok, load_err, err_code cleared; cpu_reset_req set.
- Header states each accept one byte and advance. ADDR_HI bits [7:ADDR_W-8] beyond ADDR_W ignored; address held as ADDR_W bits.
- On CNT_HI accept, range check using 17-bit arithmetic: error if start >= WORDS, CNT == 0, or start + CNT > WORDS. Error -> IDLE, load_err=1, err_code=01, cpu_reset_req=0, no writes. Else -> DATA, word index=0, sum=0.
- DATA: accepts 4 bytes into shift positions 0..3, adding each to sum; after 4th -> WRITE.
- WRITE (exactly one cycle): s_ready=0; mem_chipselect=mem_write=1, byteenable=4'hF, address=start+index, writedata=assembled word. Then index+1; if index+1 == CNT -> CSUM else -> DATA.
- CSUM: accept one byte; match -> load_ok=1; mismatch -> load_err=1, err_code=10 (memory contents already written stay). -> IDLE, cpu_reset_req=0.
- Remaining bytes of a range-rejected frame are discarded in IDLE; a data byte equal to SYNC_BYTE restarts parsing (accepted limitation; host retransmits).

## Timing
- All outputs registered. Reset values: s_ready=0 (forced low while reset_n=0), mem_* strobes 0, mem_address=0, mem_writedata=0, mem_byteenable=0, cpu_reset_req=0, busy=0, load_ok=0, load_err=0, err_code=00, state IDLE. s_ready=1 the first cycle after reset_n rises.
- Continuous s_valid: one byte per cycle, one dead cycle (WRITE) per word -> 5 cycles/word.
- Write issued the cycle after the 4th data byte is accepted; memory has no waitrequest, so write completes that cycle.
- cpu_reset_req rises the cycle after SYNC_BYTE accept; falls the cycle after CSUM or CNT_HI-error accept.
- s_valid low: state holds; no timeout.
- reset_n low mid-frame: abort immediately to reset values next edge; in-flight word not written; no status set.

## Test plan
- Frame A5 00 00 02 00, data 11 22 33 44 55 66 77 88, CSUM 0x64 -> writes 0x44332211 @0, 0x88776655 @1; load_ok=1, err_code=00; cpu_reset_req high for whole frame.
- Same frame with s_valid toggling every other cycle -> identical writes, one mem_write pulse per word, no dropped/duplicated bytes.
- Start 19999 (1F 4E), CNT 2 -> no mem_write, load_err=1, err_code=01, cpu_reset_req low after CNT_HI; start 19999 CNT 1 -> single write @19999, load_ok=1.
- Good frame with CSUM 0x65 -> both words written, load_err=1, err_code=10.
- Bytes 00 FF 13 then valid frame -> junk ignored, frame loads normally; CNT=0 -> err_code=01.
- reset_n low after 2nd data byte of a word -> no write, all outputs reset values; subsequent full frame loads correctly.
